sim_ctrl_seq: RTL and testbench

Synthesizable simulation-control sequencer that sits between the testbench clock/reset source and the testharness.
- Generates the system reset release after a programmable hold.
- Gates a preload phase for JTAG-style boot.
- Counts run cycles and enforces a cycle budget.
- Monitors N exit channels and reports the first exit with a success/failure verdict.
- Replaces ad-hoc behavioural reset, maxcycles and exit logic with one registered, parametrised block usable in RTL simulation, emulation and FPGA bring-up.

---
 rtl/sim_ctrl_pkg.sv | 29 ++
 rtl/sim_ctrl_exit_arb.sv | 31 +++
 rtl/sim_ctrl_seq.sv | 132 +++++++++++++
 tb/tb_sim_ctrl_seq.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: shared types for the simulation-control sequencer.
// FSM state enum, status bundle and a width helper.
package sim_ctrl_pkg;

  // Status fields are sized for the widest supported channel index and
  // exit code; instances use the low bits only.
  localparam int ST_CHAN_W = 16;
  localparam int ST_CODE_W = 64;

  typedef enum logic [1:0] {
    HOLD,
    LOAD,
    RUN,
    DONE
  } state_e;

  typedef struct packed {
    logic                 done;
    logic                 success;
    logic                 timeout;
    logic [ST_CHAN_W-1:0] chan;
    logic [ST_CODE_W-1:0] code;
  } status_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_ctrl_exit_arb.sv
// sim_ctrl_exit_arb: lowest-index-first priority encoder over exit strobes.
// Ports: i_valid/i_value per channel in; o_any, o_chan, o_code out.
module sim_ctrl_exit_arb
  import sim_ctrl_pkg::*;
#(
  parameter int N_EXIT = 2,
  parameter int CODE_W = 32,
  parameter int CHAN_W = clog2_min1(N_EXIT)
) (
  input  logic [N_EXIT-1:0]        i_valid,
  input  logic [N_EXIT*CODE_W-1:0] i_value,
  output logic                     o_any,
  output logic [CHAN_W-1:0]        o_chan,
  output logic [CODE_W-1:0]        o_code
);

  assign o_any = |i_valid;

  // Scan from the top so the lowest asserted channel is written last.
  always_comb begin
    o_chan = '0;
    o_code = '0;
    for (int k = N_EXIT - 1; k >= 0; k--) begin
      if (i_valid[k]) begin
        o_chan = CHAN_W'(k);
        o_code = i_value[k*CODE_W +: CODE_W];
      end
    end
  end

endmodule

// File: rtl/sim_ctrl_seq.sv
// sim_ctrl_seq: reset hold, preload gate, cycle budget and exit capture.
// Ports: clk_i/rst_ni, boot/load/budget/exit inputs; status outputs.
module sim_ctrl_seq
  import sim_ctrl_pkg::*;
#(
  parameter int N_EXIT            = 2,
  parameter int RESET_WAIT_CYCLES = 50,
  parameter int CNT_W             = 32,
  parameter int CODE_W            = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           boot_select_i,
  input  logic                           load_done_i,
  input  logic [CNT_W-1:0]               max_cycles_i,
  input  logic [N_EXIT-1:0]              exit_valid_i,
  input  logic [N_EXIT*CODE_W-1:0]       exit_value_i,
  output logic                           sys_rst_no,
  output logic                           load_req_o,
  output logic                           running_o,
  output logic [CNT_W-1:0]               cycle_cnt_o,
  output logic                           done_o,
  output logic                           success_o,
  output logic                           timeout_o,
  output logic [clog2_min1(N_EXIT)-1:0]  exit_chan_o,
  output logic [CODE_W-1:0]              exit_code_o
);

  localparam int CHAN_W = clog2_min1(N_EXIT);
  localparam int WAIT_W = clog2_min1(RESET_WAIT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(RESET_WAIT_CYCLES - 1);

  state_e             r_state;
  state_e             w_next;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_flash;
  logic               w_flash;
  logic [CNT_W-1:0]   r_cnt;
  status_t            r_st;
  logic               r_sys_rst_n;
  logic               r_load_req;
  logic               r_running;

  logic               w_any;
  logic [CHAN_W-1:0]  w_chan;
  logic [CODE_W-1:0]  w_code;
  logic               w_tmo;
  logic               w_unused;

  sim_ctrl_exit_arb #(
    .N_EXIT (N_EXIT),
    .CODE_W (CODE_W),
    .CHAN_W (CHAN_W)
  ) u_arb (
    .i_valid (exit_valid_i),
    .i_value (exit_value_i),
    .o_any   (w_any),
    .o_chan  (w_chan),
    .o_code  (w_code)
  );

  // Boot mode is taken live while holding and frozen once LOAD is entered.
  assign w_flash = (r_state == HOLD) ? boot_select_i : r_flash;

  assign w_tmo = (max_cycles_i != '0) && (r_cnt >= max_cycles_i);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HOLD: if (r_wait == WAIT_LAST) w_next = LOAD;
      LOAD: if (r_flash || load_done_i) w_next = RUN;
      RUN:  if (w_any || w_tmo) w_next = DONE;
      DONE: w_next = DONE;
      default: w_next = HOLD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= HOLD;
      r_wait      <= '0;
      r_flash     <= 1'b0;
      r_cnt       <= '0;
      r_st        <= '0;
      r_sys_rst_n <= 1'b0;
      r_load_req  <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == HOLD) begin
        r_wait  <= r_wait + 1'b1;
        r_flash <= boot_select_i;
      end
      // Counter advances only while staying in RUN, so the value at
      // DONE is the cycle on which the run ended.
      if (r_state == RUN && w_next == RUN && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == RUN) begin
        if (w_any)
          r_st <= '{done:    1'b1,
                    success: (w_code == '0),
                    timeout: 1'b0,
                    chan:    ST_CHAN_W'(w_chan),
                    code:    ST_CODE_W'(w_code)};
        else if (w_tmo)
          r_st <= '{done:    1'b1,
                    success: 1'b0,
                    timeout: 1'b1,
                    chan:    '0,
                    code:    '0};
      end
      r_sys_rst_n <= (w_next != HOLD);
      r_load_req  <= (w_next == LOAD) && !w_flash;
      r_running   <= (w_next == RUN);
    end
  end

  assign sys_rst_no  = r_sys_rst_n;
  assign load_req_o  = r_load_req;
  assign running_o   = r_running;
  assign cycle_cnt_o = r_cnt;
  assign done_o      = r_st.done;
  assign success_o   = r_st.success;
  assign timeout_o   = r_st.timeout;
  assign exit_chan_o = r_st.chan[CHAN_W-1:0];
  assign exit_code_o = r_st.code[CODE_W-1:0];

  // Upper status bits beyond this instance's widths stay zero.
  assign w_unused = ^{r_st.chan, r_st.code};

endmodule

// File: tb/tb_sim_ctrl_seq.sv
// tb_sim_ctrl_seq: randomized self-checking bench for sim_ctrl_seq.
// Main instance N_EXIT=4; second instance CNT_W=4 for saturation.
module tb_sim_ctrl_seq;

  localparam int NX  = 4;
  localparam int RWC = 50;
  localparam int CW  = 32;
  localparam int XW  = 32;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             boot;
  logic             load_done;
  logic [CW-1:0]    max_cyc;
  logic [NX-1:0]    ev;
  logic [NX*XW-1:0] eval;
  logic             sys_rst_n;
  logic             load_req;
  logic             running;
  logic [CW-1:0]    cnt;
  logic             done;
  logic             success;
  logic             timeout;
  logic [1:0]       chan;
  logic [XW-1:0]    code;

  logic             s_rst_n;
  logic             s_boot;
  logic             s_load_done;
  logic [3:0]       s_max;
  logic [0:0]       s_ev;
  logic [7:0]       s_val;
  logic             s_sys;
  logic             s_req;
  logic             s_run;
  logic [3:0]       s_cnt;
  logic             s_done;
  logic             s_succ;
  logic             s_tmo;
  logic [0:0]       s_chan;
  logic [7:0]       s_code;

  int n_checks = 0;
  int n_fail   = 0;

  sim_ctrl_seq #(
    .N_EXIT(NX), .RESET_WAIT_CYCLES(RWC), .CNT_W(CW), .CODE_W(XW)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .boot_select_i(boot),
    .load_done_i(load_done), .max_cycles_i(max_cyc),
    .exit_valid_i(ev), .exit_value_i(eval),
    .sys_rst_no(sys_rst_n), .load_req_o(load_req),
    .running_o(running), .cycle_cnt_o(cnt), .done_o(done),
    .success_o(success), .timeout_o(timeout),
    .exit_chan_o(chan), .exit_code_o(code)
  );

  sim_ctrl_seq #(
    .N_EXIT(1), .RESET_WAIT_CYCLES(1), .CNT_W(4), .CODE_W(8)
  ) u_sat (
    .clk_i(clk), .rst_ni(s_rst_n), .boot_select_i(s_boot),
    .load_done_i(s_load_done), .max_cycles_i(s_max),
    .exit_valid_i(s_ev), .exit_value_i(s_val),
    .sys_rst_no(s_sys), .load_req_o(s_req),
    .running_o(s_run), .cycle_cnt_o(s_cnt), .done_o(s_done),
    .success_o(s_succ), .timeout_o(s_tmo),
    .exit_chan_o(s_chan), .exit_code_o(s_code)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: first asserted channel in ascending order wins.
  function automatic void pick(input logic [NX-1:0] m,
                               input logic [NX*XW-1:0] v,
                               output int ch,
                               output logic [XW-1:0] c);
    logic found;
    found = 1'b0;
    ch = 0;
    c = '0;
    for (int i = 0; i < NX; i++) begin
      if (m[i] && !found) begin
        found = 1'b1;
        ch = i;
        c = v[i*XW +: XW];
      end
    end
  endfunction

  task automatic bring_up(input logic flash);
    rst_n = 1'b0;
    ev = '0;
    boot = flash;
    load_done = !flash;
    max_cyc = '0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200 && running !== 1'b1; i++) cyc();
    load_done = 1'b0;
    n_checks++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL bring_up: running=%b want 1", running);
    end
  endtask

  task automatic test_reset();
    int n_high;
    rst_n = 1'b1; boot = 1'b0; load_done = 1'b0;
    ev = '0; max_cyc = '0; eval = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sys_rst_n, load_req, running, cnt, done, success,
         timeout, chan, code} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: rst=%b req=%b run=%b cnt=%0d done=%b",
               sys_rst_n, load_req, running, cnt, done);
    end
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    n_high = 0;
    for (int i = 1; i <= RWC; i++) begin
      ev = 4'($urandom);
      load_done = (i < 40);
      cyc();
      n_checks++;
      if ({sys_rst_n, load_req} !== {2{i >= RWC}}) begin
        n_fail++;
        $display("FAIL hold_edge%0d: rst=%b req=%b want %b",
                 i, sys_rst_n, load_req, i >= RWC);
      end
    end
    if (load_req === 1'b1) n_high++;
    for (int j = 1; j <= 20; j++) begin
      ev = 4'($urandom);
      load_done = (j == 20);
      cyc();
      if (load_req === 1'b1) n_high++;
      n_checks++;
      if (j < 20) begin
        if ({load_req, running} !== 2'b10) begin
          n_fail++;
          $display("FAIL load_wait%0d: req=%b run=%b want 1 0",
                   j, load_req, running);
        end
      end else if ({load_req, running, done, cnt} !==
                   {1'b0, 1'b1, 1'b0, CW'(0)}) begin
        n_fail++;
        $display("FAIL load_exit: req=%b run=%b done=%b cnt=%0d",
                 load_req, running, done, cnt);
      end
    end
    ev = '0;
    load_done = 1'b0;
    n_checks++;
    if (n_high !== 20) begin
      n_fail++;
      $display("FAIL load_req_len: got %0d want 20", n_high);
    end
    cyc();
    n_checks++;
    if ({done, cnt} !== {1'b0, CW'(1)}) begin
      n_fail++;
      $display("FAIL first_run: done=%b cnt=%0d want 0 1", done, cnt);
    end
  endtask

  task automatic test_flash();
    logic [2:0] exp;
    rst_n = 1'b0; boot = 1'b1; load_done = 1'b0; ev = '0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= RWC + 2; i++) begin
      cyc();
      if (i == RWC) boot = 1'b0;
      exp = {1'b0, i >= RWC, i >= RWC + 1};
      n_checks++;
      if ({load_req, sys_rst_n, running} !== exp) begin
        n_fail++;
        $display("FAIL flash_edge%0d: req/rst/run=%b want %b",
                 i, {load_req, sys_rst_n, running}, exp);
      end
    end
  endtask

  task automatic test_multi_exit();
    int ech;
    logic [XW-1:0] ecode;
    logic [NX-1:0] m;
    logic [XW+CW+4:0] snap;
    bring_up(1'b1);
    repeat (3) cyc();
    eval = {32'd7, 32'd0, 32'($urandom), 32'($urandom)};
    m = 4'b1100;
    pick(m, eval, ech, ecode);
    ev = m;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_pre: done=%b want 0", done);
    end
    cyc();
    ev = 4'b0010;
    eval[1*XW +: XW] = 32'd9;
    n_checks++;
    if ({done, running, success, timeout, chan, code, cnt} !==
        {1'b1, 1'b0, ecode == '0, 1'b0, 2'(ech), ecode, CW'(3)}) begin
      n_fail++;
      $display("FAIL multi_exit: done=%b ch=%0d code=%0d succ=%b cnt=%0d want ch %0d code %0d",
               done, chan, code, success, cnt, ech, ecode);
    end
    snap = {done, success, timeout, chan, code, cnt};
    repeat (5) cyc();
    ev = '0;
    n_checks++;
    if ({done, success, timeout, chan, code, cnt} !== snap) begin
      n_fail++;
      $display("FAIL multi_frozen: ch=%0d code=%0d cnt=%0d want ch %0d code %0d",
               chan, code, cnt, ech, ecode);
    end
  endtask

  task automatic test_fail_exit();
    int r;
    bring_up(1'b1);
    r = $urandom_range(0, 10);
    repeat (r) cyc();
    eval = {32'($urandom), 32'($urandom), 32'($urandom), 32'd5};
    ev = 4'b0001 | 4'($urandom);
    cyc();
    ev = '0;
    n_checks++;
    if ({done, success, timeout, chan, code, cnt} !==
        {1'b1, 1'b0, 1'b0, 2'd0, 32'd5, CW'(r)}) begin
      n_fail++;
      $display("FAIL fail_exit: done=%b succ=%b tmo=%b ch=%0d code=%0d cnt=%0d want cnt %0d",
               done, success, timeout, chan, code, cnt, r);
    end
  endtask

  task automatic test_timeout();
    int k;
    bring_up(1'b1);
    max_cyc = CW'(100);
    k = 0;
    while (done !== 1'b1 && k < 300) begin
      cyc();
      k++;
    end
    n_checks++;
    if (k !== 101) begin
      n_fail++;
      $display("FAIL timeout_edge: done after %0d edges want 101", k);
    end
    n_checks++;
    if ({done, timeout, success, chan, code, cnt, running} !==
        {1'b1, 1'b1, 1'b0, 2'd0, 32'd0, CW'(100), 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_fields: tmo=%b succ=%b code=%0d cnt=%0d",
               timeout, success, code, cnt);
    end
    max_cyc = '0;
  endtask

  task automatic test_budget_change();
    bring_up(1'b1);
    repeat (20) cyc();
    max_cyc = CW'(5);
    cyc();
    n_checks++;
    if ({done, timeout, cnt} !== {1'b1, 1'b1, CW'(20)}) begin
      n_fail++;
      $display("FAIL budget_change: done=%b tmo=%b cnt=%0d want 1 1 20",
               done, timeout, cnt);
    end
    max_cyc = '0;
  endtask

  task automatic run_scenario(input string nm, input int m,
                              input int e, input logic [NX-1:0] mask);
    int kend;
    int ech;
    logic [XW-1:0] ecode;
    logic etmo;
    logic esucc;
    bring_up(1'b1);
    for (int i = 0; i < NX; i++) begin
      if ($urandom_range(0, 1) == 1) eval[i*XW +: XW] = '0;
      else eval[i*XW +: XW] = $urandom;
    end
    max_cyc = CW'(m);
    if (m != 0 && m < e) begin
      kend = m; etmo = 1'b1; esucc = 1'b0; ech = 0; ecode = '0;
    end else begin
      kend = e; etmo = 1'b0;
      pick(mask, eval, ech, ecode);
      esucc = (ecode == '0);
    end
    for (int k = 0; k <= kend; k++) begin
      ev = (k == e) ? mask : '0;
      cyc();
      n_checks++;
      if (k < kend) begin
        if ({done, cnt} !== {1'b0, CW'(k + 1)}) begin
          n_fail++;
          $display("FAIL %s run%0d: done=%b cnt=%0d want 0 %0d",
                   nm, k, done, cnt, k + 1);
        end
      end else if ({done, running, timeout, success, chan, code, cnt} !==
                   {1'b1, 1'b0, etmo, esucc, 2'(ech), ecode, CW'(kend)}) begin
        n_fail++;
        $display("FAIL %s end: done=%b tmo=%b succ=%b ch=%0d code=%0h cnt=%0d want tmo %b succ %b ch %0d code %0h cnt %0d",
                 nm, done, timeout, success, chan, code, cnt,
                 etmo, esucc, ech, ecode, kend);
      end
    end
    ev = '0;
    max_cyc = '0;
  endtask

  task automatic test_coincident();
    run_scenario("coincident", 30, 30, 4'($urandom_range(1, 15)));
  endtask

  task automatic test_random();
    int m;
    int e;
    for (int it = 0; it < 20; it++) begin
      m = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      e = $urandom_range(0, 45);
      run_scenario("random", m, e, 4'($urandom_range(1, 15)));
    end
  endtask

  task automatic test_mid_reset();
    bring_up(1'b1);
    max_cyc = CW'(1000);
    repeat (10) cyc();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sys_rst_n, load_req, running, cnt, done, success,
         timeout, chan, code} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: rst=%b run=%b cnt=%0d", sys_rst_n,
               running, cnt);
    end
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= RWC; i++) begin
      cyc();
      n_checks++;
      if ({sys_rst_n, running} !== {i >= RWC, 1'b0}) begin
        n_fail++;
        $display("FAIL rehold_edge%0d: rst=%b run=%b want %b 0",
                 i, sys_rst_n, running, i >= RWC);
      end
    end
    max_cyc = '0;
  endtask

  task automatic test_saturate();
    int exp;
    s_boot = 1'b1; s_load_done = 1'b0; s_max = '0;
    s_ev = '0; s_val = '0;
    @(negedge clk);
    s_rst_n = 1'b1;
    cyc();
    n_checks++;
    if ({s_sys, s_run, s_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL sat_hold: rst/run/req=%b want 100",
               {s_sys, s_run, s_req});
    end
    cyc();
    n_checks++;
    if ({s_run, s_cnt} !== {1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL sat_start: run=%b cnt=%0d", s_run, s_cnt);
    end
    for (int k = 1; k <= 25; k++) begin
      cyc();
      exp = (k > 15) ? 15 : k;
      n_checks++;
      if ({s_done, s_tmo, s_cnt} !== {2'b00, 4'(exp)}) begin
        n_fail++;
        $display("FAIL sat_cnt%0d: done=%b cnt=%0d want 0 %0d",
                 k, s_done, s_cnt, exp);
      end
    end
    s_ev = 1'b1;
    cyc();
    s_ev = 1'b0;
    n_checks++;
    if ({s_done, s_succ, s_tmo, s_chan, s_code, s_cnt} !==
        {3'b110, 1'b0, 8'd0, 4'd15}) begin
      n_fail++;
      $display("FAIL sat_exit: done=%b succ=%b tmo=%b cnt=%0d",
               s_done, s_succ, s_tmo, s_cnt);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rst_n = 1'b0; s_boot = 1'b0; s_load_done = 1'b0;
    s_max = '0; s_ev = '0; s_val = '0;
    test_reset();
    test_flash();
    test_multi_exit();
    test_fail_exit();
    test_timeout();
    test_budget_change();
    test_coincident();
    test_random();
    test_mid_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
